// File: rtl/completion_arbiter.sv
// Completion-report arbiter: one holding slot per execution unit, priority
// starving write-back > branch > any, round-robin within a class, registered output.
module completion_arbiter #(
    parameter int N_REQ        = 4,
    parameter int MSG_W        = 44,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flash,
    input  logic [N_REQ-1:0]       req_en,
    input  logic [N_REQ-1:0]       req_kind,
    input  logic [N_REQ*MSG_W-1:0] req_msg,
    output logic [N_REQ-1:0]       req_reject,
    output logic                   out_en,
    output logic                   out_kind,
    output logic [MSG_W-1:0]       out_msg,
    input  logic                   out_reject
);

    localparam int         PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [3:0] STARVE_TH = 4'(STARVE_LIMIT);

    logic [N_REQ-1:0] r_slot_valid;
    logic [N_REQ-1:0] r_slot_kind;
    logic [MSG_W-1:0] r_slot_msg [N_REQ];
    logic [3:0]       r_wait     [N_REQ];
    logic [PTR_W-1:0] r_rr_ptr;
    logic             r_out_valid;
    logic             r_out_kind;
    logic [MSG_W-1:0] r_out_msg;

    logic [N_REQ-1:0] w_starve;
    logic [N_REQ-1:0] w_branch;
    logic [N_REQ-1:0] w_cls;
    logic [PTR_W-1:0] w_grant;
    logic [PTR_W-1:0] w_rr_next;
    logic             w_found;
    logic             w_any;
    logic             w_out_free;
    logic [N_REQ-1:0] w_pop;
    logic [N_REQ-1:0] w_capture;

    // Class masks: the first non-empty class is the one arbitrated over.
    always_comb begin
        w_starve = '0;
        w_branch = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_starve[i] = r_slot_valid[i] & ~r_slot_kind[i] & (r_wait[i] >= STARVE_TH);
            w_branch[i] = r_slot_valid[i] & r_slot_kind[i];
        end
        if (|w_starve) begin
            w_cls = w_starve;
        end else if (|w_branch) begin
            w_cls = w_branch;
        end else begin
            w_cls = r_slot_valid;
        end
    end

    // Round-robin search of the winning class starting at rr_ptr.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && w_cls[(int'(r_rr_ptr) + k) % N_REQ]) begin
                w_found = 1'b1;
                w_grant = PTR_W'((int'(r_rr_ptr) + k) % N_REQ);
            end else begin
                w_found = w_found;
            end
        end
    end

    assign w_any      = |r_slot_valid;
    assign w_out_free = ~r_out_valid | ~out_reject;
    assign w_rr_next  = (w_grant == PTR_W'(N_REQ - 1)) ? '0 : w_grant + PTR_W'(1);

    // Pop and accept strobes; a slot being popped may be refilled in the same cycle.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_pop[i] = w_out_free & w_any & (w_grant == PTR_W'(i));
        end
    end

    assign req_reject = {N_REQ{flash}} | (r_slot_valid & ~w_pop);
    assign w_capture  = req_en & ~req_reject;

    // Holding slots with saturating wait counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_slot_valid <= '0;
            r_slot_kind  <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                r_slot_msg[i] <= '0;
                r_wait[i]     <= 4'd0;
            end
        end else if (flash) begin
            r_slot_valid <= '0;
            r_slot_kind  <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                r_slot_msg[i] <= '0;
                r_wait[i]     <= 4'd0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_capture[i]) begin
                    r_slot_valid[i] <= 1'b1;
                    r_slot_kind[i]  <= req_kind[i];
                    r_slot_msg[i]   <= req_msg[i*MSG_W +: MSG_W];
                    r_wait[i]       <= 4'd0;
                end else if (w_pop[i]) begin
                    r_slot_valid[i] <= 1'b0;
                    r_wait[i]       <= 4'd0;
                end else if (r_slot_valid[i] && (r_wait[i] != 4'd15)) begin
                    r_wait[i] <= r_wait[i] + 4'd1;
                end else begin
                    r_wait[i] <= r_wait[i];
                end
            end
        end
    end

    // Round-robin pointer advances past each granted unit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
        end else if (flash) begin
            r_rr_ptr <= '0;
        end else if (w_out_free && w_any) begin
            r_rr_ptr <= w_rr_next;
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end

    // Output register toward the commit queue.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_kind  <= 1'b0;
            r_out_msg   <= '0;
        end else if (flash) begin
            r_out_valid <= 1'b0;
            r_out_kind  <= 1'b0;
            r_out_msg   <= '0;
        end else if (w_out_free && w_any) begin
            r_out_valid <= 1'b1;
            r_out_kind  <= r_slot_kind[w_grant];
            r_out_msg   <= r_slot_msg[w_grant];
        end else if (w_out_free) begin
            r_out_valid <= 1'b0;
            r_out_kind  <= 1'b0;
            r_out_msg   <= '0;
        end else begin
            r_out_valid <= r_out_valid;
            r_out_kind  <= r_out_kind;
            r_out_msg   <= r_out_msg;
        end
    end

    assign out_en   = r_out_valid & ~flash;
    assign out_kind = r_out_kind;
    assign out_msg  = r_out_msg;

endmodule

// File: tb/tb_completion_arbiter.sv
// Scoreboard bench for completion_arbiter: per-unit drivers honour the
// handshake, a monitor pops expected reports on every output transfer.
module tb_completion_arbiter;

    localparam int N = 4;
    localparam int W = 44;

    logic           clock = 1'b0;
    logic           reset_n;
    logic           flash;
    logic [N-1:0]   req_en;
    logic [N-1:0]   req_kind;
    logic [N*W-1:0] req_msg;
    logic [N-1:0]   req_reject;
    logic           out_en;
    logic           out_kind;
    logic [W-1:0]   out_msg;
    logic           out_reject;

    logic           tx_kind [N][32];
    logic [W-1:0]   tx_msg  [N][32];
    int             tx_cnt  [N];
    int             tx_ptr  [N];
    bit             sent    [N];
    logic [W:0]     sb_q [$];
    int             checks = 0;
    int             failures = 0;

    completion_arbiter #(.N_REQ(N), .MSG_W(W), .STARVE_LIMIT(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .flash      (flash),
        .req_en     (req_en),
        .req_kind   (req_kind),
        .req_msg    (req_msg),
        .req_reject (req_reject),
        .out_en     (out_en),
        .out_kind   (out_kind),
        .out_msg    (out_msg),
        .out_reject (out_reject)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] mk(input int t, input int u, input int e);
        return {20'd0, 8'(t), 8'(u), 8'(e)};
    endfunction

    task automatic add(input int u, input logic k, input logic [W-1:0] m);
        tx_kind[u][tx_cnt[u]] = k;
        tx_msg[u][tx_cnt[u]]  = m;
        tx_cnt[u]++;
    endtask

    task automatic expect_out(input logic k, input logic [W-1:0] m);
        sb_q.push_back({k, m});
    endtask

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic at_mid();
        @(negedge clock);
        #1;
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) begin
            if (tx_ptr[i] < tx_cnt[i] || sent[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || pending()) && n < 100) begin
            @(posedge clock);
            n++;
        end
        #2;
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL %s_timeout actual=%0d_left required=0", name, sb_q.size());
        end
    endtask

    task automatic flash_pulse();
        cyc();
        flash = 1'b1;
        cyc();
        flash = 1'b0;
    endtask

    // Per-unit drivers: hold en/msg until a transfer is seen before the edge.
    initial begin
        req_en   = '0;
        req_kind = '0;
        req_msg  = '0;
        for (int i = 0; i < N; i++) begin
            tx_cnt[i] = 0;
            tx_ptr[i] = 0;
            sent[i]   = 1'b0;
        end
        forever begin
            @(negedge clock);
            for (int i = 0; i < N; i++) begin
                if (sent[i]) tx_ptr[i]++;
                sent[i] = 1'b0;
                if (tx_ptr[i] < tx_cnt[i]) begin
                    req_en[i]          = 1'b1;
                    req_kind[i]        = tx_kind[i][tx_ptr[i]];
                    req_msg[i*W +: W]  = tx_msg[i][tx_ptr[i]];
                end else begin
                    req_en[i]          = 1'b0;
                    req_kind[i]        = 1'b0;
                    req_msg[i*W +: W]  = '0;
                end
            end
            #4;
            for (int i = 0; i < N; i++) begin
                sent[i] = req_en[i] & ~req_reject[i];
            end
        end
    end

    // Monitor: every output transfer must match the head of the scoreboard.
    initial begin
        logic [W:0] exp_v;
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1 && out_en === 1'b1 && out_reject === 1'b0) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out actual=%0h required=none", {out_kind, out_msg});
                end else begin
                    exp_v = sb_q.pop_front();
                    chk("out_order", 64'({out_kind, out_msg}), 64'(exp_v));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        flash      = 1'b0;
        out_reject = 1'b0;
        #1;
        chk("rst_out_en", 64'(out_en), 64'd0);
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
        at_mid();
        chk("rst_out_en_after", 64'(out_en), 64'd0);
        chk("rst_out_kind", 64'(out_kind), 64'd0);
        chk("rst_out_msg", 64'(out_msg), 64'd0);
        chk("rst_req_reject", 64'(req_reject), 64'd0);

        // Single report latency: accepted in cycle 1, presented in cycle 3 only.
        cyc();
        add(2, 1'b0, 44'h00000000A5);
        expect_out(1'b0, 44'h00000000A5);
        at_mid();
        chk("t1_req_reject2_c1", 64'(req_reject[2]), 64'd0);
        chk("t1_out_en_c1", 64'(out_en), 64'd0);
        at_mid();
        chk("t1_out_en_c2", 64'(out_en), 64'd0);
        at_mid();
        chk("t1_out_en_c3", 64'(out_en), 64'd1);
        chk("t1_out_msg_c3", 64'(out_msg), 64'h00000000A5);
        at_mid();
        chk("t1_out_en_c4", 64'(out_en), 64'd0);
        drain("t1");

        // Three write-backs, rr_ptr=0: order 0,1,3.
        flash_pulse();
        add(0, 1'b0, mk(2, 0, 0));
        add(1, 1'b0, mk(2, 1, 0));
        add(3, 1'b0, mk(2, 3, 0));
        expect_out(1'b0, mk(2, 0, 0));
        expect_out(1'b0, mk(2, 1, 0));
        expect_out(1'b0, mk(2, 3, 0));
        drain("t2");
        // rr_ptr back at 0: unit 0 beats unit 1.
        add(1, 1'b0, mk(2, 1, 1));
        add(0, 1'b0, mk(2, 0, 1));
        expect_out(1'b0, mk(2, 0, 1));
        expect_out(1'b0, mk(2, 1, 1));
        drain("t2_rr");

        // Branch from unit 3 overtakes write-back from unit 0.
        add(0, 1'b0, mk(3, 0, 0));
        add(3, 1'b1, mk(3, 3, 0));
        expect_out(1'b1, mk(3, 3, 0));
        expect_out(1'b0, mk(3, 0, 0));
        drain("t3");

        // Starvation: unit 1 write-back under continuous branch pressure.
        flash_pulse();
        add(1, 1'b0, mk(4, 1, 0));
        for (int e = 0; e < 4; e++) begin
            add(0, 1'b1, mk(4, 0, e));
            add(2, 1'b1, mk(4, 2, e));
            add(3, 1'b1, mk(4, 3, e));
        end
        expect_out(1'b1, mk(4, 0, 0));
        expect_out(1'b1, mk(4, 2, 0));
        expect_out(1'b1, mk(4, 3, 0));
        expect_out(1'b1, mk(4, 0, 1));
        expect_out(1'b1, mk(4, 2, 1));
        expect_out(1'b1, mk(4, 3, 1));
        expect_out(1'b1, mk(4, 0, 2));
        expect_out(1'b1, mk(4, 2, 2));
        expect_out(1'b0, mk(4, 1, 0));
        expect_out(1'b1, mk(4, 2, 3));
        expect_out(1'b1, mk(4, 3, 2));
        expect_out(1'b1, mk(4, 0, 3));
        expect_out(1'b1, mk(4, 3, 3));
        repeat (11) at_mid();
        chk("t4_starve_out_en", 64'(out_en), 64'd1);
        chk("t4_starve_out_msg", 64'(out_msg), 64'(mk(4, 1, 0)));
        drain("t4");

        // Backpressure with all slots full.
        flash_pulse();
        out_reject = 1'b1;
        for (int u = 0; u < N; u++) begin
            add(u, 1'b0, mk(5, u, 0));
            add(u, 1'b0, mk(5, u, 1));
        end
        for (int e = 0; e < 2; e++) begin
            for (int u = 0; u < N; u++) begin
                expect_out(1'b0, mk(5, u, e));
            end
        end
        repeat (2) at_mid();
        for (int c = 0; c < 5; c++) begin
            at_mid();
            chk("t5_hold_out_en", 64'(out_en), 64'd1);
            chk("t5_hold_out_msg", 64'(out_msg), 64'(mk(5, 0, 0)));
            chk("t5_hold_req_reject", 64'(req_reject), 64'hF);
        end
        cyc();
        out_reject = 1'b0;
        drain("t5");

        // Flash with three slots and the output register occupied.
        flash_pulse();
        out_reject = 1'b1;
        for (int u = 0; u < N; u++) begin
            add(u, 1'b0, mk(6, u, 0));
        end
        repeat (3) at_mid();
        chk("t6_out_en_before", 64'(out_en), 64'd1);
        cyc();
        flash = 1'b1;
        at_mid();
        chk("t6_flash_out_en", 64'(out_en), 64'd0);
        chk("t6_flash_req_reject", 64'(req_reject), 64'hF);
        cyc();
        flash      = 1'b0;
        out_reject = 1'b0;
        at_mid();
        chk("t6_after_out_en", 64'(out_en), 64'd0);
        chk("t6_after_req_reject", 64'(req_reject), 64'd0);
        cyc();
        add(1, 1'b0, mk(6, 1, 1));
        expect_out(1'b0, mk(6, 1, 1));
        at_mid();
        chk("t6_new_req_reject1", 64'(req_reject[1]), 64'd0);
        at_mid();
        chk("t6_new_out_en_c2", 64'(out_en), 64'd0);
        at_mid();
        chk("t6_new_out_en_c3", 64'(out_en), 64'd1);
        chk("t6_new_out_msg_c3", 64'(out_msg), 64'(mk(6, 1, 1)));
        drain("t6");

        repeat (3) at_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/completion_arbiter.md
Name: completion_arbiter

Overview:
- Arbitrates completion reports from N execution units into the single completion-report input of the commit queue.
- Each unit gets a one-entry holding slot.
- Selection order: starving write-back reports first, then branch reports (so mispredicts resolve early), then all others round-robin.
- Output is registered and honours commit-queue backpressure; flash empties the block.

Parameters:
- N_REQ, 4, number of requesting execution units (2..8).
- MSG_W, 44, width of the opaque completion payload; commit_id sits in the payload and is not interpreted here.
- STARVE_LIMIT, 8, wait cycles after which a held write-back report is starving (1..15).

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flash  in  1  synchronous pipeline flush, active high.
- req_en  in  N_REQ  per-unit report valid.
- req_kind  in  N_REQ  per-unit report kind; 1 = branch, 0 = write-back.
- req_msg  in  N_REQ*MSG_W  per-unit payload; unit i occupies bits [i*MSG_W +: MSG_W].
- req_reject  out  N_REQ  per-unit "not accepted this cycle".
- out_en  out  1  report valid toward commit queue.
- out_kind  out  1  kind of presented report.
- out_msg  out  MSG_W  payload of presented report.
- out_reject  in  1  commit queue refuses the report this cycle.

Behaviour:
- Handshake, both sides:
  - A transfer occurs in a cycle where en=1 and reject=0.
  - The sender holds en/msg stable until the transfer.
- Reset (reset_n=0, asynchronous):
  - All slots and the output register are invalid.
  - out_en=0, out_kind=0, out_msg=0.
  - Wait counters=0, rr_ptr=0.
  - req_reject is 0 after reset.
- Slot i holds slot_valid, slot_kind, slot_msg and a 4-bit saturating wait counter.
- out_free = ~out_valid | ~out_reject.
- pop[i] = out_free & (grant == i).
- req_reject[i] = flash | (slot_valid[i] & ~pop[i]). This is a combinational path from out_reject; it is permitted.
- Capture: req_en[i] & ~req_reject[i] writes the slot and clears its counter. A same-cycle pop and refill of slot i is legal.
- Wait counter: increments, saturating at 15, each cycle the slot is valid and not popped.
- Arbitration is combinational over valid slots, evaluated every cycle; the first non-empty class wins:
  1. Starving: kind=0 and counter ≥ STARVE_LIMIT.
  2. Branch: kind=1.
  3. All valid slots.
- Within the winning class, the first index at or after rr_ptr wins, wrapping mod N_REQ.
- On each pop, rr_ptr ← (grant+1) mod N_REQ. Otherwise rr_ptr holds.
- Output register:
  - Loaded from the granted slot when out_free and any slot is valid.
  - Cleared when out_free and no slot is valid.
  - Holds when out_reject=1.
  - out_en = out_valid & ~flash.
- Latency: a report accepted in cycle T appears on out_en no earlier than T+2. Throughput is 1 report/cycle with continuous demand.
- flash (cycle F):
  - out_en forced to 0 and all req_reject=1 during F.
  - At the end of F: all slots, output register and counters cleared; rr_ptr ← 0.
  - flash wins over capture, pop and load in the same cycle.
- Boundaries:
  - All slots full and out_reject held: nothing is accepted or lost, and counters saturate.
  - Only a single slot valid: it wins regardless of class.
  - A branch arriving while a write-back is starving waits behind it.
  - No report is ever duplicated or dropped except by flash.

Test Plan:
- Unit 2 sends kind 0, msg 0x00000000A5 in cycle 1 -> req_reject[2]=0 in cycle 1; out_en=1, out_msg=0x...A5 in cycle 3 only; out_en=0 in cycle 4.
- Units 0,1,3 all send write-backs in the same cycle with rr_ptr=0 and out_reject=0 -> outputs in order 0,1,3 on consecutive cycles; rr_ptr ends at 0.
- Unit 0 sends a write-back and unit 3 sends a branch in the same cycle -> unit 3 presented first, unit 0 next cycle.
- Unit 1 holds a write-back while units 0,2,3 send a new branch every cycle (STARVE_LIMIT=8) -> unit 1 presented within 10 cycles of capture, ahead of pending branches.
- out_reject held for 5 cycles with 4 slots full -> out_en/out_msg stable; req_reject=4'b1111; every report emerges exactly once after release.
- flash asserted while 3 slots and the output register are valid -> out_en=0 during flash; out_en=0 and req_reject=0 the next cycle; the next accepted report appears 2 cycles after acceptance.
